// File: rtl/mw_addsub_seq.sv
// Multi-word add/subtract sequencer: one 32-bit slice, LSW first, carry chained between words.
// Accept to out_valid takes WORDS cycles; in DONE the outputs hold until out_ready.
module mw_addsub_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   result,
  output logic                  c_out,
  output logic                  ovf,
  output logic                  busy
);

  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q;
  logic          op_q;
  logic [IW-1:0] idx;
  logic          carry;
  logic          accept;
  logic          last_word;

  logic [31:0]   a_w, b_w, bx;
  logic [32:0]   sum;
  logic [31:0]   low31;
  logic [31:0]   s;
  logic          co;
  logic          c31;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    last_word = (idx == LAST);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single 32-bit slice; carry into bit 31 is recovered from the low 31 bits for overflow.
  always_comb begin
    a_w   = a_q[idx*32 +: 32];
    b_w   = b_q[idx*32 +: 32];
    bx    = op_q ? ~b_w : b_w;
    sum   = {1'b0, a_w} + {1'b0, bx} + {32'b0, carry};
    low31 = {1'b0, a_w[30:0]} + {1'b0, bx[30:0]} + {31'b0, carry};
    s     = sum[31:0];
    co    = sum[32];
    c31   = low31[31];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        idx   <= '0;
        carry <= op;
      end else if (state == CALC) begin
        result[idx*32 +: 32] <= s;
        carry <= co;
        idx   <= last_word ? '0 : idx + 1'b1;
        if (last_word) begin
          c_out <= co;
          ovf   <= c31 ^ co;
        end
      end
    end
  end

endmodule

// File: tb/tb_mw_addsub_seq.sv
// Randomized and directed bench for mw_addsub_seq (WORDS=4) against a whole-width arithmetic model.
module tb_mw_addsub_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  mw_addsub_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: full-width unsigned sum/difference, overflow from exact signed result.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                       output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0]          u;
    logic signed [W+1:0] ex, got;
    if (!o) begin
      u  = {1'b0, x} + {1'b0, y};
      r  = u[W-1:0];
      c  = u[W];
      ex = $signed({{2{x[W-1]}}, x}) + $signed({{2{y[W-1]}}, y});
    end else begin
      r  = x - y;
      c  = (x >= y);
      ex = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y});
    end
    got = $signed({{2{r[W-1]}}, r});
    v   = (ex != got);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*32 +: 32] = 32'hFFFF_FFFF;
        1:       v[i*32 +: 32] = 32'h0;
        2:       v[i*32 +: 32] = 32'h7FFF_FFFF;
        3:       v[i*32 +: 32] = 32'h8000_0000;
        default: v[i*32 +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  // Drives one operation and collects its outputs; no checking here.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                        output logic [W-1:0] r, output logic c, output logic v,
                        output int lat, output logic timeout);
    timeout = 1'b0;
    lat     = 0;
    @(negedge clk);
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    if (!in_ready) timeout = 1'b1;
    a = x; b = y; op = o; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) timeout = 1'b1;
    r = result; c = c_out; v = ovf;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (result !== '0)      begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if ({c_out, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {c_out, ovf}); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    logic         to [5];
    logic [W-1:0] tr [5];
    logic         tc [5];
    logic         tv [5];
    logic [W-1:0] r;
    logic         c, v, tmo;
    int           lat;
    ta[0] = {W{1'b1}};                     tb[0] = 1; to[0] = 0; tr[0] = '0;              tc[0] = 1; tv[0] = 0;
    ta[1] = '0;                            tb[1] = 1; to[1] = 1; tr[1] = {W{1'b1}};       tc[1] = 0; tv[1] = 0;
    ta[2] = {1'b0, {(W-1){1'b1}}};         tb[2] = 1; to[2] = 0; tr[2] = {1'b1, {(W-1){1'b0}}}; tc[2] = 0; tv[2] = 1;
    ta[3] = 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF; tb[3] = 1; to[3] = 0;
    tr[3] = 128'h00000001_00000000_00000000_00000000; tc[3] = 0; tv[3] = 0;
    ta[4] = 5;                             tb[4] = 5; to[4] = 1; tr[4] = '0;              tc[4] = 1; tv[4] = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], to[i], r, c, v, lat, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout got=1 exp=0", i); end
      checks++; if (lat != WORDS) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, WORDS); end
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, tr[i]); end
      checks++; if ({c, v} !== {tc[i], tv[i]}) begin errors++; $display("FAIL dir%0d_flags got=%b exp=%b", i, {c, v}, {tc[i], tv[i]}); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, r, er;
    logic         o, c, v, ec, ev, tmo;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      x = rnd_operand(); y = rnd_operand(); o = 1'($urandom_range(0, 1));
      model(x, y, o, er, ec, ev);
      run_op(x, y, o, r, c, v, lat, tmo);
      checks++; if (tmo || lat != WORDS) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, WORDS); end
      checks++; if (r !== er) begin errors++; $display("FAIL rnd%0d_result op=%b got=%h exp=%h", i, o, r, er); end
      checks++; if ({c, v} !== {ec, ev}) begin errors++; $display("FAIL rnd%0d_flags op=%b got=%b exp=%b", i, o, {c, v}, {ec, ev}); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x1, y1, x2, y2, e1, e2;
    logic         c1, v1, c2, v2;
    int           k;
    x1 = rnd_operand(); y1 = rnd_operand();
    x2 = rnd_operand(); y2 = rnd_operand();
    model(x1, y1, 1'b0, e1, c1, v1);
    model(x2, y2, 1'b1, e2, c2, v2);
    @(negedge clk);
    a = x1; b = y1; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = x2; b = y2; op = 1'b1;
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({out_valid, in_ready, busy} !== 3'b101) begin errors++; $display("FAIL bp%0d_hs got=%b exp=101", i, {out_valid, in_ready, busy}); end
      checks++; if (result !== e1 || {c_out, ovf} !== {c1, v1}) begin errors++; $display("FAIL bp%0d_hold got=%h/%b exp=%h/%b", i, result, {c_out, ovf}, e1, {c1, v1}); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got=%b exp=01", {out_valid, in_ready}); end
    checks++; if (result !== e1) begin errors++; $display("FAIL bp_after_hold got=%h exp=%h", result, e1); end
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_second_timeout got=0 exp=1"); end
    checks++; if (result !== e2 || {c_out, ovf} !== {c2, v2}) begin errors++; $display("FAIL bp_second got=%h/%b exp=%h/%b", result, {c_out, ovf}, e2, {c2, v2}); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x, y, er, r;
    logic         ec, ev, c, v, tmo;
    int           lat;
    x = {4{32'h1234_5678}}; y = {4{32'h0F0F_0F0F}};
    model(x, y, 1'b0, er, ec, ev);
    @(negedge clk);
    a = x; b = y; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (result[63:0] !== er[63:0] || busy !== 1'b1) begin errors++; $display("FAIL mid_partial got=%h exp=%h", result[63:0], er[63:0]); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin errors++; $display("FAIL mid_rst_hs got=%b exp=100", {in_ready, out_valid, busy}); end
    checks++; if (result !== '0 || {c_out, ovf} !== 2'b00) begin errors++; $display("FAIL mid_rst_out got=%h/%b exp=0/00", result, {c_out, ovf}); end
    run_op(128'd2, 128'd3, 1'b0, r, c, v, lat, tmo);
    checks++; if (tmo || r !== 128'd5 || {c, v} !== 2'b00) begin errors++; $display("FAIL mid_fresh got=%h/%b exp=5/00", r, {c, v}); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] qr[$];
    logic [1:0]   qf[$];
    logic [W-1:0] er;
    logic         ec, ev;
    int           n_acc, n_done, last_acc;
    n_acc = 0; n_done = 0; last_acc = -1;
    @(negedge clk);
    a = rnd_operand(); b = rnd_operand(); op = 1'($urandom_range(0, 1));
    out_ready = 1'b1; in_valid = 1'b1;
    for (int cyc = 0; cyc < 80 && n_done < 4; cyc++) begin
      if (out_valid) begin
        checks++; if (qr.size() == 0 || result !== qr[0] || {c_out, ovf} !== qf[0]) begin
          errors++; $display("FAIL b2b_result got=%h/%b exp=%h", result, {c_out, ovf}, (qr.size() != 0) ? qr[0] : '0);
        end
        if (qr.size() != 0) begin void'(qr.pop_front()); void'(qf.pop_front()); end
        n_done++;
      end
      if (in_ready && in_valid) begin
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != WORDS + 2) begin errors++; $display("FAIL b2b_period got=%0d exp=%0d", cyc - last_acc, WORDS + 2); end
        end
        last_acc = cyc;
        model(a, b, op, er, ec, ev);
        qr.push_back(er); qf.push_back({ec, ev});
        n_acc++;
      end else if (!in_ready) begin
        a = rnd_operand(); b = rnd_operand(); op = 1'($urandom_range(0, 1));
        if (n_acc >= 4) in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (n_done != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", n_done); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
